// File: rtl/fll_cfg_master.sv
// FLL configuration port initiator: 4-phase req/ack handshake
// with ack/lock synchronizers and a hung-FLL timeout.
module fll_cfg_master #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_wrn_i,
   input  logic [1:0]  cmd_add_i,
   input  logic [31:0] cmd_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        fll_req_o,
   output logic        fll_wrn_o,
   output logic [1:0]  fll_add_o,
   output logic [31:0] fll_data_o,
   input  logic        fll_ack_i,
   input  logic [31:0] fll_r_data_i,
   input  logic        fll_lock_i,
   output logic        lock_o,
   output logic        lock_lost_o
);

   localparam int CW =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TMAX =
      CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, REQ, REL, RSP} state_t;

   state_t        state_q, state_d;
   logic          req_q, req_d;
   logic          wrn_q, wrn_d;
   logic [1:0]    add_q, add_d;
   logic [31:0]   data_q, data_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lock_prev_q;
   logic          ack_s, lock_s;
   logic          tmo;

   if (SYNC_STAGES == 0) begin : g_nosync
      assign ack_s  = fll_ack_i;
      assign lock_s = fll_lock_i;
   end else begin : g_sync
      logic [SYNC_STAGES-1:0] ack_sync_q, lock_sync_q;

      // Shift ack and lock through the synchronizer chains
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            ack_sync_q  <= '0;
            lock_sync_q <= '0;
         end else begin
            ack_sync_q[0]  <= fll_ack_i;
            lock_sync_q[0] <= fll_lock_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               ack_sync_q[i]  <= ack_sync_q[i-1];
               lock_sync_q[i] <= lock_sync_q[i-1];
            end
         end
      end

      assign ack_s  = ack_sync_q[SYNC_STAGES-1];
      assign lock_s = lock_sync_q[SYNC_STAGES-1];
   end

   assign tmo = (TIMEOUT_CYCLES != 0) && (cnt_q == TMAX);

   // Handshake FSM next-state, datapath and strobes
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      wrn_d       = wrn_q;
      add_d       = add_q;
      data_d      = data_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      cmd_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            cmd_ready_o = ~ack_s;
            if (cmd_valid_i && !ack_s) begin
               wrn_d   = cmd_wrn_i;
               add_d   = cmd_add_i;
               data_d  = cmd_wdata_i;
               req_d   = 1'b1;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            cnt_d = cnt_q + 1'b1;
            if (ack_s) begin
               rdata_d = fll_r_data_i;
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = REL;
            end else if (tmo) begin
               rdata_d = '0;
               req_d   = 1'b0;
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = REL;
            end
         end
         REL: begin
            cnt_d = cnt_q + 1'b1;
            if (!ack_s) begin
               state_d = RSP;
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = RSP;
            end
         end
         RSP: begin
            rsp_valid_o = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         wrn_q       <= 1'b1;
         add_q       <= '0;
         data_q      <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         lock_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         wrn_q       <= wrn_d;
         add_q       <= add_d;
         data_q      <= data_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         lock_prev_q <= lock_s;
      end
   end

   assign fll_req_o   = req_q;
   assign fll_wrn_o   = wrn_q;
   assign fll_add_o   = add_q;
   assign fll_data_o  = data_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
   assign lock_o      = lock_s;
   assign lock_lost_o = lock_prev_q & ~lock_s;

endmodule

// File: tb/tb_fll_cfg_master.sv
// Directed bench for fll_cfg_master with echo/tied/manual FLL
// responder and a response scoreboard.
module tb_fll_cfg_master;

   localparam int ECHO = 0, TIED0 = 1, MANUAL = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_wrn = 1'b1;
   logic [1:0]  cmd_add = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        fll_req, fll_wrn;
   logic [1:0]  fll_add;
   logic [31:0] fll_data;
   logic        fll_ack;
   logic [31:0] resp_data = '0;
   logic        fll_lock = 1'b0;
   logic        lock_out, lock_lost;
   logic        man_ack = 1'b0;
   int          mode = ECHO;

   int n_assert = 0;
   int n_fail   = 0;
   int n_rsp    = 0;
   int cyc      = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          acc;
      int          lat;
   } sb_t;

   sb_t sb[$];
   sb_t e;

   fll_cfg_master #(
      .SYNC_STAGES   (2),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_wrn_i   (cmd_wrn),
      .cmd_add_i   (cmd_add),
      .cmd_wdata_i (cmd_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .fll_req_o   (fll_req),
      .fll_wrn_o   (fll_wrn),
      .fll_add_o   (fll_add),
      .fll_data_o  (fll_data),
      .fll_ack_i   (fll_ack),
      .fll_r_data_i(resp_data),
      .fll_lock_i  (fll_lock),
      .lock_o      (lock_out),
      .lock_lost_o (lock_lost)
   );

   assign fll_ack = (mode == ECHO)  ? fll_req :
                    (mode == TIED0) ? 1'b0 : man_ack;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pop and compare each completion against the scoreboard
   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         n_rsp++;
         n_assert++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_rsp observed=rsp_valid expected=none");
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_lat", 64'(cyc - e.acc), 64'(e.lat));
         end
      end
   end

   task automatic issue(input logic wrn, input logic [1:0] add,
                        input logic [31:0] wdata, input bit push,
                        input logic xerr, input logic [31:0] xrdata,
                        input int lat);
      int t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("ready_wait", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_wrn   = wrn;
      cmd_add   = add;
      cmd_wdata = wdata;
      @(posedge clk);
      #1;
      if (push) sb.push_back('{xerr, xrdata, cyc, lat});
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      int t = 0;
      while (n_rsp < target && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("rsp_wait", 64'(n_rsp), 64'(target));
   endtask

   task automatic chk_reset(string s);
      chk({s, "_req"}, 64'(fll_req), 64'd0);
      chk({s, "_wrn"}, 64'(fll_wrn), 64'd1);
      chk({s, "_add"}, 64'(fll_add), 64'd0);
      chk({s, "_data"}, 64'(fll_data), 64'd0);
      chk({s, "_rvalid"}, 64'(rsp_valid), 64'd0);
      chk({s, "_rdata"}, 64'(rsp_rdata), 64'd0);
      chk({s, "_rerr"}, 64'(rsp_err), 64'd0);
      chk({s, "_lock"}, 64'(lock_out), 64'd0);
      chk({s, "_lost"}, 64'(lock_lost), 64'd0);
      chk({s, "_ready"}, 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_reset("rst");
      rst = 1'b0;

      // Write with echo responder
      mode = ECHO;
      resp_data = 32'h0BAD0BAD;
      issue(1'b0, 2'd2, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0BAD0BAD, 6);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("wr_req_hi", 64'(fll_req), 64'd1);
         chk("wr_add", 64'(fll_add), 64'd2);
         chk("wr_data", 64'(fll_data), 64'hDEADBEEF);
         chk("wr_wrn", 64'(fll_wrn), 64'd0);
      end
      @(negedge clk);
      chk("wr_req_lo", 64'(fll_req), 64'd0);
      repeat (2) @(negedge clk);
      @(negedge clk);
      chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("wr_ready_rsp", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      chk("wr_rsp_drop", 64'(rsp_valid), 64'd0);
      chk("wr_ready_back", 64'(cmd_ready), 64'd1);
      wait_rsp(1);

      // Two reads
      resp_data = 32'h12345678;
      issue(1'b1, 2'd0, 32'h0, 1'b1, 1'b0, 32'h12345678, 6);
      wait_rsp(2);
      resp_data = 32'hA5A5A5A5;
      issue(1'b1, 2'd1, 32'h0, 1'b1, 1'b0, 32'hA5A5A5A5, 6);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rd_wrn", 64'(fll_wrn), 64'd1);
         chk("rd_add", 64'(fll_add), 64'd1);
      end
      wait_rsp(3);

      // Timeout in REQ, ack tied low
      mode = TIED0;
      issue(1'b0, 2'd3, 32'h11111111, 1'b1, 1'b1, 32'h0, 17);
      repeat (16) @(negedge clk);
      chk("to_req_hi", 64'(fll_req), 64'd1);
      @(negedge clk);
      chk("to_req_lo", 64'(fll_req), 64'd0);
      wait_rsp(4);

      // Stuck ack: timeout in REL
      mode = MANUAL;
      man_ack = 1'b0;
      resp_data = 32'hCAFEF00D;
      issue(1'b1, 2'd2, 32'h0, 1'b1, 1'b1, 32'hCAFEF00D, 19);
      @(negedge clk);
      man_ack = 1'b1;
      wait_rsp(5);
      @(negedge clk);
      chk("stuck_ready0", 64'(cmd_ready), 64'd0);
      man_ack = 1'b0;
      @(negedge clk);
      chk("stuck_ready1", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      chk("stuck_ready2", 64'(cmd_ready), 64'd1);

      // Reset in the middle of REQ
      mode = TIED0;
      issue(1'b0, 2'd1, 32'h00000077, 1'b0, 1'b0, 32'h0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("mid_req_hi", 64'(fll_req), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset("mid");
      repeat (20) @(negedge clk);
      chk("mid_no_rsp", 64'(n_rsp), 64'd5);

      // Lock synchronizer and lost pulse
      mode = ECHO;
      @(negedge clk);
      fll_lock = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         chk("lock_o", 64'(lock_out), 64'(k >= 2 && k <= 11));
         chk("lock_lost", 64'(lock_lost), 64'(k == 12));
         if (k == 10) fll_lock = 1'b0;
      end

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fll_cfg_master.md
# fll_cfg_master

Initiator side of the FLL configuration port: accepts single register read/write commands from the SoC control logic and runs the 4-phase req/ack handshake that the clock/reset generator's FLL responds to (req, write-enable-bar, 2-bit address, 32-bit data out; ack, 32-bit read data back). It sits in the SoC clock domain between the APB control registers and the clock/reset generator. It synchronizes the FLL's ack and lock signals, which are asynchronous on ASIC targets. It also guards against a hung FLL with a timeout.

## Interface
Parameters:
- SYNC_STAGES, 2, flops on fll_ack_i and fll_lock_i; 0 = no synchronizer (combinational ack path, FPGA echo model)
- TIMEOUT_CYCLES, 255, max cycles spent in REQ or REL before abort; 0 disables timeout

Ports:
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_wrn_i  in  1  1 = read, 0 = write (FLL write-enable-bar polarity)
- cmd_add_i  in  2  FLL register address
- cmd_wdata_i  in  32  write data
- rsp_valid_o  out  1  one-cycle completion pulse, no backpressure
- rsp_rdata_o  out  32  read data, valid with rsp_valid_o
- rsp_err_o  out  1  timeout flag, valid with rsp_valid_o
- fll_req_o  out  1  handshake request
- fll_wrn_o  out  1  write-enable-bar to FLL
- fll_add_o  out  2  address to FLL
- fll_data_o  out  32  write data to FLL
- fll_ack_i  in  1  FLL acknowledge (async)
- fll_r_data_i  in  32  FLL read data, stable while ack high
- fll_lock_i  in  1  FLL lock (async)
- lock_o  out  1  synchronized lock
- lock_lost_o  out  1  one-cycle pulse on synchronized lock falling edge

## Operation
- ack_s = fll_ack_i through SYNC_STAGES flops (reset 0); lock_s likewise.
- States: IDLE, REQ, REL, RSP.
- IDLE: cmd_ready_o = 1 only if ack_s = 0. On valid&ready: register wrn/add/wdata onto fll_wrn_o/fll_add_o/fll_data_o; set fll_req_o = 1; clear err; go to REQ.
- REQ: if ack_s = 1: capture fll_r_data_i into rsp_rdata_o; fll_req_o = 0; go to REL. Otherwise, on timeout: fll_req_o = 0; err = 1; rsp_rdata_o = 0; go to REL.
- REL: if ack_s = 0, go to RSP. Otherwise, on timeout: err = 1; go to RSP.
- RSP: rsp_valid_o = 1 for exactly one cycle; rsp_err_o = err; go to IDLE.
- Timeout counter: cleared on entry to REQ and to REL, increments each cycle in those states. Timeout fires when the count reaches TIMEOUT_CYCLES−1 (TIMEOUT_CYCLES cycles in state). Counter width is clog2(TIMEOUT_CYCLES+1). If ack condition and timeout occur in the same cycle, ack wins and err stays 0.
- fll_wrn_o/fll_add_o/fll_data_o hold their values from accept until the next accept; they are stable whenever fll_req_o = 1.
- rsp_rdata_o holds its value until the next capture. For writes it carries whatever fll_r_data_i showed at ack.
- lock_o = lock_s. lock_lost_o = lock_s_prev & ~lock_s.
- Reset values: fll_req_o 0, fll_wrn_o 1, fll_add_o 0, fll_data_o 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0, lock_o 0, lock_lost_o 0, state IDLE, sync flops 0. cmd_ready_o is 1 in the cycle after reset, provided ack_s = 0.
- Reset mid-transaction: abort immediately. fll_req_o drops in the cycle after the reset edge and no rsp_valid_o is issued. A still-high ack blocks new commands via the ack_s guard.

## Timing
- Edge numbering: E0 = accept edge. fll_req_o is high from E0 onward.
- With N = SYNC_STAGES and a zero-delay echo responder (ack = req):
  - REQ→REL at edge E(N+1); fll_req_o is low from that edge.
  - REL→RSP at edge E(2N+2).
  - rsp_valid_o is high for the cycle after E(2N+2) and falls at E(2N+3).
  - cmd_ready_o rises at E(2N+3).
  - Accept to rsp_valid is therefore 2N+2 cycles: 6 for N = 2, 2 for N = 0.
- Throughput with the echo responder: one command per 2N+3 cycles.
- lock_o lags fll_lock_i by N cycles. lock_lost_o pulses in the cycle lock_o falls.

## Test plan
- Write, N=2, echo responder: cmd add=2, wrn=0, wdata=0xDEADBEEF → fll_req_o high 1..3 cycles with add/data stable; rsp_valid_o exactly 6 cycles after accept; rsp_err_o=0; cmd_ready_o back the next cycle.
- Read: responder drives 0x12345678 while ack high → rsp_rdata_o=0x12345678, rsp_err_o=0. A back-to-back second read of add=1 returning 0xA5A5A5A5 gives that value and fll_wrn_o=1 throughout.
- Timeout, TIMEOUT_CYCLES=16, ack tied 0 → fll_req_o falls after 16 cycles in REQ; rsp_valid_o with rsp_err_o=1 and rsp_rdata_o=0 one cycle later (REL sees ack_s=0 at once).
- Stuck ack, TIMEOUT_CYCLES=16: ack rises then stays high → 16 cycles in REL, then rsp_err_o=1. cmd_ready_o stays 0 while ack_s=1 and returns 1 N cycles after ack falls.
- Reset mid-REQ (responder never acks): rst_i for 1 cycle → fll_req_o=0 the cycle after reset, no rsp_valid_o, all outputs at reset values.
- Lock: fll_lock_i 0→1 for 10 cycles then →0 → lock_o follows 2 cycles late; lock_lost_o single pulse coincident with lock_o falling; no pulse on the rising transition.
